// File: rtl/reservation_station_mc.sv
// Multi-channel reservation station: holds dispatched ALU ops until operands arrive
// over the CDB buses, then issues the lowest-index ready entry through a valid/ready slot.
module reservation_station_mc #(
  parameter int ADDR_WIDTH   = 32,
  parameter int ROB_WIDTH    = 4,
  parameter int RS_WIDTH     = 3,
  parameter int RS_DEPTH     = 1 << RS_WIDTH,
  parameter int CDB_CHANNELS = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           disp_en_in,
  input  logic [6:0]                     disp_op_in,
  input  logic [ADDR_WIDTH-1:0]          disp_pc_in,
  input  logic                           disp_qj_vld_in,
  input  logic                           disp_qk_vld_in,
  input  logic [ROB_WIDTH-1:0]           disp_qj_in,
  input  logic [ROB_WIDTH-1:0]           disp_qk_in,
  input  logic [31:0]                    disp_vj_in,
  input  logic [31:0]                    disp_vk_in,
  input  logic [31:0]                    disp_imm_in,
  input  logic [ROB_WIDTH-1:0]           disp_rob_in,
  output logic                           full_out,
  output logic [RS_WIDTH:0]              count_out,
  input  logic [CDB_CHANNELS-1:0]        cdb_en_in,
  input  logic [CDB_CHANNELS*ROB_WIDTH-1:0] cdb_rob_in,
  input  logic [CDB_CHANNELS*32-1:0]     cdb_val_in,
  output logic                           iss_valid_out,
  input  logic                           iss_ready_in,
  output logic [6:0]                     iss_op_out,
  output logic [ADDR_WIDTH-1:0]          iss_pc_out,
  output logic [31:0]                    iss_vj_out,
  output logic [31:0]                    iss_vk_out,
  output logic [31:0]                    iss_imm_out,
  output logic [ROB_WIDTH-1:0]           iss_rob_out
);

  logic [RS_DEPTH-1:0]   busy, qj_pend, qk_pend;
  logic [6:0]            e_op  [RS_DEPTH];
  logic [ADDR_WIDTH-1:0] e_pc  [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  e_qj  [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  e_qk  [RS_DEPTH];
  logic [31:0]           e_vj  [RS_DEPTH];
  logic [31:0]           e_vk  [RS_DEPTH];
  logic [31:0]           e_imm [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  e_rob [RS_DEPTH];

  logic [RS_DEPTH-1:0]   wj_pend, wk_pend;
  logic [31:0]           wj_val [RS_DEPTH];
  logic [31:0]           wk_val [RS_DEPTH];
  logic                  dj_pend, dk_pend;
  logic [31:0]           dj_val, dk_val;
  logic                  sel_found, free_found, iss_open, iss_take, disp_acc;
  logic [RS_WIDTH-1:0]   sel_idx, free_idx;

  assign full_out = &busy;
  assign iss_open = ~iss_valid_out | iss_ready_in;
  assign iss_take = iss_open & sel_found;
  assign disp_acc = disp_en_in & ~full_out & ~flush_in;

  // Channels are scanned high to low so the lowest matching channel lands last and wins.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (busy[i] & ~qj_pend[i] & ~qk_pend[i]) begin
        sel_found = 1'b1;
        sel_idx   = RS_WIDTH'(i);
      end
      if (~busy[i]) begin
        free_found = 1'b1;
        free_idx   = RS_WIDTH'(i);
      end
    end
    dj_pend = disp_qj_vld_in;
    dj_val  = disp_vj_in;
    dk_pend = disp_qk_vld_in;
    dk_val  = disp_vk_in;
    for (int c = CDB_CHANNELS - 1; c >= 0; c--) begin
      if (disp_qj_vld_in && cdb_en_in[c] && cdb_rob_in[c*ROB_WIDTH +: ROB_WIDTH] == disp_qj_in) begin
        dj_pend = 1'b0;
        dj_val  = cdb_val_in[c*32 +: 32];
      end
      if (disp_qk_vld_in && cdb_en_in[c] && cdb_rob_in[c*ROB_WIDTH +: ROB_WIDTH] == disp_qk_in) begin
        dk_pend = 1'b0;
        dk_val  = cdb_val_in[c*32 +: 32];
      end
    end
    for (int e = 0; e < RS_DEPTH; e++) begin
      wj_pend[e] = qj_pend[e];
      wj_val[e]  = e_vj[e];
      wk_pend[e] = qk_pend[e];
      wk_val[e]  = e_vk[e];
      for (int c = CDB_CHANNELS - 1; c >= 0; c--) begin
        if (qj_pend[e] && cdb_en_in[c] && cdb_rob_in[c*ROB_WIDTH +: ROB_WIDTH] == e_qj[e]) begin
          wj_pend[e] = 1'b0;
          wj_val[e]  = cdb_val_in[c*32 +: 32];
        end
        if (qk_pend[e] && cdb_en_in[c] && cdb_rob_in[c*ROB_WIDTH +: ROB_WIDTH] == e_qk[e]) begin
          wk_pend[e] = 1'b0;
          wk_val[e]  = cdb_val_in[c*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy          <= '0;
      qj_pend       <= '0;
      qk_pend       <= '0;
      count_out     <= '0;
      iss_valid_out <= 1'b0;
      iss_op_out    <= '0;
      iss_pc_out    <= '0;
      iss_vj_out    <= '0;
      iss_vk_out    <= '0;
      iss_imm_out   <= '0;
      iss_rob_out   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        e_op[i]  <= '0;
        e_pc[i]  <= '0;
        e_qj[i]  <= '0;
        e_qk[i]  <= '0;
        e_vj[i]  <= '0;
        e_vk[i]  <= '0;
        e_imm[i] <= '0;
        e_rob[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy          <= '0;
        count_out     <= '0;
        iss_valid_out <= 1'b0;
      end else begin
        qj_pend <= wj_pend;
        qk_pend <= wk_pend;
        for (int i = 0; i < RS_DEPTH; i++) begin
          e_vj[i] <= wj_val[i];
          e_vk[i] <= wk_val[i];
        end
        if (iss_open) begin
          iss_valid_out <= sel_found;
          if (sel_found) begin
            iss_op_out      <= e_op[sel_idx];
            iss_pc_out      <= e_pc[sel_idx];
            iss_vj_out      <= e_vj[sel_idx];
            iss_vk_out      <= e_vk[sel_idx];
            iss_imm_out     <= e_imm[sel_idx];
            iss_rob_out     <= e_rob[sel_idx];
            busy[sel_idx]   <= 1'b0;
          end
        end
        // The free slot comes from registered busy, so it can never be the entry being issued.
        if (disp_acc && free_found) begin
          busy[free_idx]    <= 1'b1;
          e_op[free_idx]    <= disp_op_in;
          e_pc[free_idx]    <= disp_pc_in;
          e_qj[free_idx]    <= disp_qj_in;
          e_qk[free_idx]    <= disp_qk_in;
          e_imm[free_idx]   <= disp_imm_in;
          e_rob[free_idx]   <= disp_rob_in;
          qj_pend[free_idx] <= dj_pend;
          qk_pend[free_idx] <= dk_pend;
          e_vj[free_idx]    <= dj_val;
          e_vk[free_idx]    <= dk_val;
        end
        count_out <= count_out + (RS_WIDTH+1)'(disp_acc) - (RS_WIDTH+1)'(iss_take);
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_mc.sv
// Directed scenarios followed by random traffic, all checked against a slot-array
// reference model; a few directed points also check hand-derived constants.
module tb_reservation_station_mc;
  localparam int AW = 32, RW = 4, SW = 3, D = 8, C = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n_in, rdy_in, flush_in, disp_en_in, disp_qj_vld_in, disp_qk_vld_in;
  logic [6:0] disp_op_in;
  logic [AW-1:0] disp_pc_in;
  logic [RW-1:0] disp_qj_in, disp_qk_in, disp_rob_in;
  logic [31:0] disp_vj_in, disp_vk_in, disp_imm_in;
  logic full_out;
  logic [SW:0] count_out;
  logic [C-1:0] cdb_en_in;
  logic [C*RW-1:0] cdb_rob_in;
  logic [C*32-1:0] cdb_val_in;
  logic iss_valid_out, iss_ready_in;
  logic [6:0] iss_op_out;
  logic [AW-1:0] iss_pc_out;
  logic [31:0] iss_vj_out, iss_vk_out, iss_imm_out;
  logic [RW-1:0] iss_rob_out;

  reservation_station_mc #(.ADDR_WIDTH(AW), .ROB_WIDTH(RW), .RS_WIDTH(SW), .RS_DEPTH(D), .CDB_CHANNELS(C)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_en_in(disp_en_in), .disp_op_in(disp_op_in), .disp_pc_in(disp_pc_in),
    .disp_qj_vld_in(disp_qj_vld_in), .disp_qk_vld_in(disp_qk_vld_in),
    .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in), .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
    .disp_imm_in(disp_imm_in), .disp_rob_in(disp_rob_in), .full_out(full_out), .count_out(count_out),
    .cdb_en_in(cdb_en_in), .cdb_rob_in(cdb_rob_in), .cdb_val_in(cdb_val_in),
    .iss_valid_out(iss_valid_out), .iss_ready_in(iss_ready_in), .iss_op_out(iss_op_out),
    .iss_pc_out(iss_pc_out), .iss_vj_out(iss_vj_out), .iss_vk_out(iss_vk_out),
    .iss_imm_out(iss_imm_out), .iss_rob_out(iss_rob_out)
  );

  int total = 0, passed = 0;

  // Reference model: one record per slot plus the issue register.
  bit            m_busy [D];
  bit            m_jp [D], m_kp [D];
  logic [RW-1:0] m_qj [D], m_qk [D], m_rob [D];
  logic [31:0]   m_vj [D], m_vk [D], m_imm [D];
  logic [6:0]    m_op [D];
  logic [AW-1:0] m_pc [D];
  bit            m_iv;
  logic [138:0]  m_iss;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_busy[i] = 0; m_jp[i] = 0; m_kp[i] = 0;
    end
    m_iv = 0;
    m_iss = '0;
  endtask

  function automatic bit cdb_hit(input logic [RW-1:0] tag, output logic [31:0] val);
    for (int c = 0; c < C; c++)
      if (cdb_en_in[c] && cdb_rob_in[c*RW +: RW] == tag) begin
        val = cdb_val_in[c*32 +: 32];
        return 1;
      end
    val = '0;
    return 0;
  endfunction

  task automatic model_step();
    int sel = -1, fre = -1;
    logic [31:0] v;
    if (!rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < D; i++) m_busy[i] = 0;
      m_iv = 0;
      return;
    end
    for (int i = 0; i < D; i++) begin
      if (sel < 0 && m_busy[i] && !m_jp[i] && !m_kp[i]) sel = i;
      if (fre < 0 && !m_busy[i]) fre = i;
    end
    for (int i = 0; i < D; i++) if (m_busy[i]) begin
      if (m_jp[i] && cdb_hit(m_qj[i], v)) begin m_jp[i] = 0; m_vj[i] = v; end
      if (m_kp[i] && cdb_hit(m_qk[i], v)) begin m_kp[i] = 0; m_vk[i] = v; end
    end
    if (!m_iv || iss_ready_in) begin
      if (sel >= 0) begin
        m_iss = {m_op[sel], m_pc[sel], m_vj[sel], m_vk[sel], m_imm[sel], m_rob[sel]};
        m_iv = 1;
        m_busy[sel] = 0;
      end else m_iv = 0;
    end
    if (disp_en_in && fre >= 0) begin
      m_busy[fre] = 1;
      m_op[fre] = disp_op_in; m_pc[fre] = disp_pc_in; m_imm[fre] = disp_imm_in; m_rob[fre] = disp_rob_in;
      m_qj[fre] = disp_qj_in; m_qk[fre] = disp_qk_in;
      m_jp[fre] = disp_qj_vld_in; m_vj[fre] = disp_vj_in;
      m_kp[fre] = disp_qk_vld_in; m_vk[fre] = disp_vk_in;
      if (m_jp[fre] && cdb_hit(m_qj[fre], v)) begin m_jp[fre] = 0; m_vj[fre] = v; end
      if (m_kp[fre] && cdb_hit(m_qk[fre], v)) begin m_kp[fre] = 0; m_vk[fre] = v; end
    end
  endtask

  task automatic check_model();
    int n = 0;
    bit f = 1;
    for (int i = 0; i < D; i++) begin
      n += int'(m_busy[i]);
      f &= m_busy[i];
    end
    chk("model_valid", 160'(iss_valid_out), 160'(m_iv));
    chk("model_count", 160'(count_out), 160'(n));
    chk("model_full", 160'(full_out), 160'(f));
    chk("model_fields", 160'({iss_op_out, iss_pc_out, iss_vj_out, iss_vk_out, iss_imm_out, iss_rob_out}), 160'(m_iss));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check_model();
  endtask

  task automatic idle();
    rdy_in = 1; flush_in = 0; disp_en_in = 0; cdb_en_in = '0;
  endtask

  task automatic disp(input logic [6:0] op, input bit qjv, input logic [RW-1:0] qj, input logic [31:0] vj,
                      input bit qkv, input logic [RW-1:0] qk, input logic [31:0] vk, input logic [RW-1:0] rob);
    disp_en_in = 1; disp_op_in = op;
    disp_qj_vld_in = qjv; disp_qj_in = qj; disp_vj_in = vj;
    disp_qk_vld_in = qkv; disp_qk_in = qk; disp_vk_in = vk;
    disp_rob_in = rob; disp_pc_in = 32'h1000 + 32'(rob); disp_imm_in = 32'(rob) * 3;
  endtask

  task automatic cdb(input int ch, input logic [RW-1:0] tag, input logic [31:0] val);
    cdb_en_in[ch] = 1'b1;
    cdb_rob_in[ch*RW +: RW] = tag;
    cdb_val_in[ch*32 +: 32] = val;
  endtask

  initial begin
    idle();
    iss_ready_in = 1;
    cdb_rob_in = '0; cdb_val_in = '0;
    disp(7'h0, 0, 0, 0, 0, 0, 0, 0);
    disp_en_in = 0;
    rst_n_in = 0;
    model_reset();
    #12;
    check_model();
    chk("reset_iss_fields", 160'({iss_op_out, iss_pc_out, iss_vj_out, iss_vk_out, iss_imm_out, iss_rob_out}), 160'(0));
    @(negedge clk_in);
    rst_n_in = 1;

    // Ready dispatch -> issue one cycle later
    disp(7'h33, 0, 0, 5, 0, 0, 7, 3);
    cycle();
    idle();
    cycle();
    chk("ready_valid", 160'(iss_valid_out), 160'(1));
    chk("ready_vj", 160'(iss_vj_out), 160'(5));
    chk("ready_vk", 160'(iss_vk_out), 160'(7));
    chk("ready_rob", 160'(iss_rob_out), 160'(3));

    // Dispatch-time bypass from channel 1, then wakeup with two channels matching
    disp(7'h13, 1, 6, 0, 0, 0, 1, 5);
    cdb(1, 6, 32'hAB);
    cycle();
    idle();
    cycle();
    chk("bypass_vj", 160'(iss_vj_out), 160'(32'hAB));
    disp(7'h13, 1, 2, 0, 0, 0, 9, 6);
    cycle();
    idle();
    cycle();
    cdb(0, 2, 32'h55);
    cdb(1, 2, 32'h66);
    cycle();
    chk("wake_not_yet", 160'(iss_valid_out), 160'(0));
    idle();
    cycle();
    chk("wake_valid", 160'(iss_valid_out), 160'(1));
    chk("wake_low_ch", 160'(iss_vj_out), 160'(32'h55));

    // Fill all entries with pending operands
    for (int i = 0; i < D; i++) begin
      disp(7'h33, 1, RW'(8 + i), 0, 0, 0, 32'(i), RW'(i));
      cycle();
    end
    chk("full_flag", 160'(full_out), 160'(1));
    chk("full_count", 160'(count_out), 160'(8));
    disp(7'h33, 0, 0, 1, 0, 0, 1, 15);
    cycle();
    chk("full_drop", 160'(count_out), 160'(8));
    idle();
    cdb(0, 12, 32'h1234);
    cycle();
    idle();
    cycle();
    chk("full_issue_rob", 160'(iss_rob_out), 160'(4));
    chk("full_cleared", 160'(full_out), 160'(0));
    for (int t = 8; t < 16; t++) begin
      if (t == 12) continue;
      idle();
      cdb(t % 2, RW'(t), 32'(t * 17));
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Backpressure
    iss_ready_in = 0;
    disp(7'h33, 0, 0, 32'h11, 0, 0, 1, 1);
    cycle();
    disp(7'h33, 0, 0, 32'h22, 0, 0, 2, 2);
    cycle();
    idle();
    repeat (2) begin
      cycle();
      chk("bp_hold_rob", 160'(iss_rob_out), 160'(1));
      chk("bp_count", 160'(count_out), 160'(1));
    end
    iss_ready_in = 1;
    cycle();
    chk("bp_second_rob", 160'(iss_rob_out), 160'(2));
    cycle();

    // Flush with simultaneous dispatch and CDB
    disp(7'h33, 1, 3, 0, 0, 0, 4, 7);
    cycle();
    disp(7'h33, 1, 3, 0, 0, 0, 4, 8);
    cycle();
    flush_in = 1;
    disp(7'h33, 0, 0, 1, 0, 0, 2, 9);
    cdb(0, 3, 32'h77);
    cycle();
    chk("flush_count", 160'(count_out), 160'(0));
    chk("flush_valid", 160'(iss_valid_out), 160'(0));
    idle();
    cdb(0, 3, 32'h77);
    repeat (3) begin
      cycle();
      chk("flush_quiet", 160'(iss_valid_out), 160'(0));
    end

    // Asynchronous reset with 5 entries busy and a held issue slot
    idle();
    iss_ready_in = 0;
    disp(7'h33, 0, 0, 1, 0, 0, 1, 10);
    cycle();
    for (int i = 0; i < 5; i++) begin
      disp(7'h33, 1, 7, 0, 0, 0, 0, RW'(i));
      cycle();
    end
    idle();
    chk("prereset_count", 160'(count_out), 160'(5));
    chk("prereset_valid", 160'(iss_valid_out), 160'(1));
    #2 rst_n_in = 0;
    #1;
    chk("async_rst_valid", 160'(iss_valid_out), 160'(0));
    chk("async_rst_count", 160'(count_out), 160'(0));
    chk("async_rst_full", 160'(full_out), 160'(0));
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 39) == 0);
      iss_ready_in = ($urandom_range(0, 9) < 7);
      disp($urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 15));
      disp_en_in = ($urandom_range(0, 9) < 6);
      disp_pc_in = $urandom;
      disp_imm_in = $urandom;
      cdb_en_in = C'($urandom_range(0, 3));
      cdb_rob_in = (C*RW)'($urandom);
      cdb_val_in = {$urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
